// File: rtl/segre_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : segre_fetch_unit
//  Brief    : Instruction fetch stage with a FETCH_DEPTH-entry prefetch queue,
//             multiple outstanding in-order memory requests and taken-branch
//             redirect handling (queue flush plus discard of stale responses).
//  Options  : SEGRE_FETCH_MISALIGN_EN adds misalign_o and blocks issue after a
//             misaligned redirect until the next aligned one.
//  Revision : 1.0 - initial release
// ============================================================================
module segre_fetch_unit #(
   parameter int unsigned          ADDR_SIZE   = 32,
   parameter int unsigned          WORD_SIZE   = 32,
   parameter int unsigned          FETCH_DEPTH = 4,
   parameter logic [ADDR_SIZE-1:0] RESET_PC    = '0
) (
   input  logic                 clk_i,
   input  logic                 rsn_i,
   input  logic                 fetch_en_i,
   output logic                 mem_rd_o,
   output logic [ADDR_SIZE-1:0] mem_addr_o,
   input  logic                 mem_gnt_i,
   input  logic                 mem_rvalid_i,
   input  logic [WORD_SIZE-1:0] mem_rdata_i,
   output logic                 instr_valid_o,
   output logic [WORD_SIZE-1:0] instr_o,
   output logic [ADDR_SIZE-1:0] pc_o,
   input  logic                 id_ready_i,
   input  logic                 tkbr_i,
   input  logic [ADDR_SIZE-1:0] new_pc_i
`ifdef SEGRE_FETCH_MISALIGN_EN
   ,
   output logic                 misalign_o
`endif
);

   localparam int unsigned          PTR_W      = $clog2(FETCH_DEPTH);
   localparam int unsigned          CNT_W      = PTR_W + 1;
   localparam logic [CNT_W:0]       DEPTH_L    = (CNT_W+1)'(FETCH_DEPTH);
   localparam logic [ADDR_SIZE-1:0] PC_STEP    = ADDR_SIZE'(4);

   typedef enum logic [0:0] {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [ADDR_SIZE-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_SIZE-1:0] resp_pc_q, resp_pc_d;
   logic [CNT_W-1:0]     outst_q, outst_d;
   logic [CNT_W-1:0]     drop_q, drop_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;

   logic [ADDR_SIZE-1:0] pc_mem_q   [FETCH_DEPTH];
   logic [WORD_SIZE-1:0] data_mem_q [FETCH_DEPTH];

   logic [ADDR_SIZE-1:0] load_pc;
   logic                 issue_block;
   logic                 rd_int;
   logic                 grant;
   logic                 push;
   logic                 pop;
   logic [CNT_W:0]       inflight;

`ifdef SEGRE_FETCH_MISALIGN_EN
   logic misalign_q, misalign_d;

   // A misaligned target is loaded as-is; issue stays blocked until realigned
   assign load_pc     = new_pc_i;
   assign issue_block = misalign_q;
   assign misalign_o  = misalign_q;

   // Misalign flag follows the alignment of every redirect target
   always_comb begin
      misalign_d = misalign_q;
      if (tkbr_i) begin
         misalign_d = |new_pc_i[1:0];
      end
   end

   // Misalign flag register
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= misalign_d;
      end
   end
`else
   // Without misalign support the two low target bits are simply cleared
   assign load_pc     = new_pc_i & ~ADDR_SIZE'(3);
   assign issue_block = 1'b0;
`endif

   // Queue occupancy plus in-flight requests bounds issue so every response
   // is guaranteed a free slot; the output is held low while in reset.
   assign inflight   = {1'b0, cnt_q} + {1'b0, outst_q};
   assign rd_int     = fetch_en_i && (state_q == RUN) && !issue_block && (inflight < DEPTH_L);
   assign mem_rd_o   = rd_int && rsn_i;
   assign mem_addr_o = fetch_pc_q;
   assign grant      = rd_int && mem_gnt_i;

   // Head of queue is presented combinationally; zero while empty
   assign instr_valid_o = (cnt_q != '0);
   assign instr_o       = instr_valid_o ? data_mem_q[rd_ptr_q] : '0;
   assign pc_o          = instr_valid_o ? pc_mem_q[rd_ptr_q]   : '0;

   // A flush overrides both a same-cycle push and a same-cycle pop
   assign push = mem_rvalid_i && (drop_q == '0) && !tkbr_i;
   assign pop  = instr_valid_o && id_ready_i && !tkbr_i;

   // Next-state logic: counters, PCs, queue pointers and redirect FSM
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      outst_d    = outst_q + CNT_W'(grant) - CNT_W'(mem_rvalid_i);
      drop_d     = drop_q;
      cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d   = wr_ptr_q + PTR_W'(push);

      if (mem_rvalid_i && (drop_q != '0)) begin
         drop_d = drop_q - CNT_W'(1);
      end
      if (grant) begin
         fetch_pc_d = fetch_pc_q + PC_STEP;
      end
      if (push) begin
         resp_pc_d = resp_pc_q + PC_STEP;
      end

      case (state_q)
         RUN: begin
            // Everything still in flight after this cycle belongs to the old path
            if (tkbr_i) begin
               drop_d = outst_d;
               if (outst_d != '0) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (drop_q == '0) begin
               state_d = RUN;
            end
         end
         default: state_d = RUN;
      endcase

      if (tkbr_i) begin
         fetch_pc_d = load_pc;
         resp_pc_d  = load_pc;
         cnt_d      = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end
   end

   // Control and counter registers
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         outst_q    <= '0;
         drop_q     <= '0;
         cnt_q      <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         drop_q     <= drop_d;
         cnt_q      <= cnt_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
      end
   end

   // Queue storage; contents are only visible through a valid head
   always_ff @(posedge clk_i) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= resp_pc_q;
         data_mem_q[wr_ptr_q] <= mem_rdata_i;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_segre_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_segre_fetch_unit
//  Brief    : Self-checking bench for segre_fetch_unit (default build).
//             Epoch-tagged request model: responses to requests issued before
//             the latest redirect are stale and must never reach ID.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_segre_fetch_unit;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h100;

   logic        clk = 1'b0;
   logic        rsn_i = 1'b0;
   logic        fetch_en_i = 1'b0;
   logic        mem_gnt_i = 1'b0;
   logic        mem_rvalid_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        id_ready_i = 1'b0;
   logic        tkbr_i = 1'b0;
   logic [31:0] new_pc_i = '0;
   logic        mem_rd_o;
   logic [31:0] mem_addr_o;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] pc_o;

   segre_fetch_unit #(
      .ADDR_SIZE  (32),
      .WORD_SIZE  (32),
      .FETCH_DEPTH(DEPTH),
      .RESET_PC   (RPC)
   ) dut (
      .clk_i        (clk),
      .rsn_i        (rsn_i),
      .fetch_en_i   (fetch_en_i),
      .mem_rd_o     (mem_rd_o),
      .mem_addr_o   (mem_addr_o),
      .mem_gnt_i    (mem_gnt_i),
      .mem_rvalid_i (mem_rvalid_i),
      .mem_rdata_i  (mem_rdata_i),
      .instr_valid_o(instr_valid_o),
      .instr_o      (instr_o),
      .pc_o         (pc_o),
      .id_ready_i   (id_ready_i),
      .tkbr_i       (tkbr_i),
      .new_pc_i     (new_pc_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          ep;
   } req_t;

   req_t        pend[$];     // bench memory: requests awaiting a response
   logic [31:0] exp_q[$];    // PCs expected to reach ID, in order
   logic [31:0] exp_pc;      // next address the fetch unit must request
   int          epoch;
   bit          drain_tail;  // a stale response retired last cycle
   int          gnt_pct, resp_pct;
   int          checks, failures;

   // per-step snapshot of DUT outputs for directed checks
   logic        s_rd, s_val;
   logic [31:0] s_addr, s_pc;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
   endfunction

   function automatic int stale_cnt();
      int n = 0;
      foreach (pend[i]) if (pend[i].ep != epoch) n++;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive memory side, check at negedge, update model at posedge
   task automatic step();
      bit   exp_rd, gnt, pop, dt;
      req_t r;
      mem_gnt_i = ($urandom_range(0, 99) < gnt_pct);
      if (pend.size() > 0 && $urandom_range(0, 99) < resp_pct) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = memf(pend[0].addr);
      end else begin
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = $urandom;
      end
      @(negedge clk);
      exp_rd = fetch_en_i && (stale_cnt() == 0) && !drain_tail
               && (exp_q.size() + pend.size() < DEPTH);
      chk("mem_rd", 32'(mem_rd_o), 32'(exp_rd));
      if (exp_rd) chk("mem_addr", mem_addr_o, exp_pc);
      chk("instr_valid", 32'(instr_valid_o), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("pc", pc_o, exp_q[0]);
         chk("instr", instr_o, memf(exp_q[0]));
      end
      s_rd   = mem_rd_o;
      s_addr = mem_addr_o;
      s_val  = instr_valid_o;
      s_pc   = pc_o;
      gnt    = exp_rd && mem_gnt_i;
      pop    = (exp_q.size() != 0) && id_ready_i && !tkbr_i;
      @(posedge clk);
      dt = 1'b0;
      if (pop) void'(exp_q.pop_front());
      if (mem_rvalid_i) begin
         r = pend.pop_front();
         if (r.ep != epoch) dt = 1'b1;
         else if (!tkbr_i) exp_q.push_back(r.addr);
      end
      if (gnt) begin
         pend.push_back('{addr: exp_pc, ep: epoch});
         exp_pc = exp_pc + 32'd4;
      end
      if (tkbr_i) begin
         epoch++;
         exp_q.delete();
         exp_pc = new_pc_i & ~32'h3;
      end
      drain_tail = dt;
      #1;
   endtask

   task automatic rst_outputs(input string tag);
      chk({tag, "_mem_rd"}, 32'(mem_rd_o), 32'd0);
      chk({tag, "_valid"}, 32'(instr_valid_o), 32'd0);
      chk({tag, "_instr"}, instr_o, 32'd0);
      chk({tag, "_pc"}, pc_o, 32'd0);
   endtask

   task automatic do_reset(input bit immediate);
      rsn_i        = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_gnt_i    = 1'b0;
      tkbr_i       = 1'b0;
      if (immediate) begin
         #1;
         rst_outputs("rst_now");
      end
      @(posedge clk);
      #1;
      rst_outputs("rst");
      rsn_i = 1'b1;
      pend.delete();
      exp_q.delete();
      exp_pc     = RPC;
      epoch++;
      drain_tail = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int          n;
      logic [31:0] first_addr, first_pc;
      checks = 0; failures = 0; epoch = 0;
      gnt_pct = 100; resp_pct = 100;

      // Streaming from RESET_PC with immediate grants and 1-cycle responses
      fetch_en_i = 1'b1; id_ready_i = 1'b1;
      @(posedge clk);
      do_reset(1'b0);
      for (int i = 0; i < 6; i++) begin
         step();
         if (i < 3) begin
            chk("t1_rd", 32'(s_rd), 32'd1);
            chk("t1_addr", s_addr, RPC + 32'(4 * i));
         end
         if (i == 1) chk("t1_lat_valid", 32'(s_val), 32'd0);
         if (i == 2) begin
            chk("t1_valid", 32'(s_val), 32'd1);
            chk("t1_pc", s_pc, RPC);
         end
      end

      // ID stalled: queue fills with exactly DEPTH grants, one pop frees one slot
      do_reset(1'b0);
      id_ready_i = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (s_rd) n++;
      end
      chk("t2_grants", 32'(n), 32'd4);
      chk("t2_rd_off", 32'(s_rd), 32'd0);
      id_ready_i = 1'b1;
      step();
      chk("t2_pop_pc", s_pc, 32'h100);
      id_ready_i = 1'b0;
      n = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (s_rd) begin
            n++;
            chk("t2_new_addr", s_addr, 32'h110);
         end
      end
      chk("t2_one_more", 32'(n), 32'd1);

      // Redirect with two requests outstanding
      do_reset(1'b0);
      id_ready_i = 1'b1; resp_pct = 0;
      step(); step();
      fetch_en_i = 1'b0; tkbr_i = 1'b1; new_pc_i = 32'h200;
      step();
      tkbr_i = 1'b0; fetch_en_i = 1'b1; resp_pct = 100;
      first_addr = '1; first_pc = '1;
      for (int i = 0; i < 15; i++) begin
         step();
         if (i == 0) chk("t3_drain_rd", 32'(s_rd), 32'd0);
         if (s_rd && first_addr == '1) first_addr = s_addr;
         if (s_val && first_pc == '1) first_pc = s_pc;
      end
      chk("t3_first_req", first_addr, 32'h200);
      chk("t3_first_pc", first_pc, 32'h200);

      // Redirect coinciding with a grant and a response, one outstanding before
      do_reset(1'b0);
      step();
      tkbr_i = 1'b1; new_pc_i = 32'h302;
      step();
      chk("t4_tk_rd", 32'(s_rd), 32'd1);
      tkbr_i = 1'b0;
      first_pc = '1;
      for (int i = 0; i < 12; i++) begin
         step();
         if (i == 0) chk("t4_drain_rd", 32'(s_rd), 32'd0);
         if (s_val && first_pc == '1) first_pc = s_pc;
      end
      chk("t4_first_pc", first_pc, 32'h300);

      // Grant withheld for three cycles: request held stable
      do_reset(1'b0);
      gnt_pct = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_hold_rd", 32'(s_rd), 32'd1);
         chk("t5_hold_addr", s_addr, 32'h100);
      end
      gnt_pct = 100;
      step();
      chk("t5_gnt_addr", s_addr, 32'h100);
      step();
      chk("t5_next_addr", s_addr, 32'h104);

      // Reset mid-stream with three outstanding requests
      do_reset(1'b0);
      resp_pct = 0;
      step(); step(); step();
      do_reset(1'b1);
      resp_pct = 100;
      step();
      chk("t6_restart_addr", s_addr, RPC);
      chk("t6_restart_rd", 32'(s_rd), 32'd1);

      // Randomized traffic against the model
      gnt_pct = 70; resp_pct = 60;
      for (int i = 0; i < 3000; i++) begin
         fetch_en_i = ($urandom_range(0, 99) < 90);
         id_ready_i = ($urandom_range(0, 99) < 70);
         tkbr_i     = ($urandom_range(0, 99) < 4);
         new_pc_i   = $urandom & 32'h0000_FFFF;
         if ($urandom_range(0, 999) < 2) do_reset(1'b1);
         else step();
      end
      tkbr_i = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
